lsu_mem_if: RTL and testbench

- Load/store unit between the execute stage and the data-memory bus.
- Consumes the decoder's MemRW/MemSize/MemUnsigned together with the ALU address and rs2 store data.
- Issues one word-aligned bus transaction with byte enables, then returns the aligned, sign- or zero-extended load result to the WB mux.
- Stalls the pipeline until the access completes, is rejected as misaligned, or times out.

---
 rtl/lsu_mem_if.sv | 96 +++++++++
 tb/tb_lsu_mem_if.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/lsu_mem_if.sv
// lsu_mem_if: load/store unit bridging EX to a word-aligned data bus with
// byte enables, load formatting, misalignment rejection and bus timeout.
module lsu_mem_if #(
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        MemRW,
  input  logic [1:0]  MemSize,
  input  logic        MemUnsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        fault,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic we_r, uns_r, mis_r, flt_r;
  logic [1:0] size_r, off_r;
  logic mis, tmo, fin, busy;
  logic [31:0] sh, fmt, st_wd;
  logic [3:0] st_be;
  assign mis = (MemSize == 2'b11) | (MemSize == 2'b01 & addr[0]) | (MemSize == 2'b10 & |addr[1:0]);
  assign busy = state == REQ || state == WAIT;
  assign tmo = cnt == CNT_W'(TIMEOUT_CYC - 1);
  // a response counts in REQ only when it arrives together with the grant
  assign fin = dmem_rvalid & (state == WAIT | (state == REQ & dmem_gnt));
  assign sh = dmem_rdata >> {off_r, 3'b000};
  assign fmt = size_r == 2'b00 ? {{24{~uns_r & sh[7]}}, sh[7:0]} :
               size_r == 2'b01 ? {{16{~uns_r & sh[15]}}, sh[15:0]} : sh;
  assign st_wd = MemSize == 2'b00 ? {4{wdata[7:0]}} :
                 MemSize == 2'b01 ? {2{wdata[15:0]}} : wdata;
  assign st_be = !MemRW ? 4'hf :
                 MemSize == 2'b00 ? 4'b0001 << addr[1:0] :
                 MemSize == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'hf;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = req_valid ? (mis ? DONE : REQ) : IDLE;
      REQ:  nxt = (fin || tmo) ? DONE : dmem_gnt ? WAIT : REQ;
      WAIT: nxt = (fin || tmo) ? DONE : WAIT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      we_r <= 1'b0;
      uns_r <= 1'b0;
      size_r <= 2'b00;
      off_r <= 2'b00;
      mis_r <= 1'b0;
      flt_r <= 1'b0;
      rdata <= '0;
      dmem_addr <= '0;
      dmem_wdata <= '0;
      dmem_be <= '0;
    end else begin
      state <= nxt;
      cnt <= busy ? cnt + 1'b1 : '0;
      mis_r <= state == IDLE && req_valid && mis;
      flt_r <= busy && tmo && !fin;
      if (state == IDLE && req_valid) begin
        we_r <= MemRW;
        uns_r <= MemUnsigned;
        size_r <= MemSize;
        off_r <= addr[1:0];
        dmem_addr <= {addr[31:2], 2'b00};
        dmem_wdata <= st_wd;
        dmem_be <= st_be;
      end
      if (fin && !we_r) rdata <= fmt;
    end
  end
  assign dmem_req = state == REQ;
  assign dmem_we = dmem_req & we_r;
  assign done = state == DONE;
  assign stall = (state == IDLE & req_valid) | busy;
  assign misalign = mis_r;
  assign fault = flt_r;
endmodule

// File: tb/tb_lsu_mem_if.sv
// tb_lsu_mem_if: directed vector table plus multi-cycle sequences for lsu_mem_if.
module tb_lsu_mem_if;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, MemRW = 1'b0, MemUnsigned = 1'b0;
  logic [1:0] MemSize = 2'b00;
  logic [31:0] addr = '0, wdata = '0, dmem_rdata = '0;
  logic dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic stall, done, misalign, fault, dmem_req, dmem_we;
  logic [31:0] rdata, dmem_addr, dmem_wdata;
  logic [3:0] dmem_be;
  logic stall_t, done_t, misalign_t, fault_t, dmem_req_t, dmem_we_t;
  logic [31:0] rdata_t, dmem_addr_t, dmem_wdata_t;
  logic [3:0] dmem_be_t;
  int nv = 0, nf = 0;

  always #5 clk = ~clk;

  lsu_mem_if dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .MemRW(MemRW), .MemSize(MemSize),
    .MemUnsigned(MemUnsigned), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
    .rdata(rdata), .misalign(misalign), .fault(fault), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  lsu_mem_if #(.TIMEOUT_CYC(4), .CNT_W(3)) dut_t (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .MemRW(MemRW), .MemSize(MemSize),
    .MemUnsigned(MemUnsigned), .addr(addr), .wdata(wdata), .stall(stall_t), .done(done_t),
    .rdata(rdata_t), .misalign(misalign_t), .fault(fault_t), .dmem_req(dmem_req_t), .dmem_we(dmem_we_t),
    .dmem_addr(dmem_addr_t), .dmem_wdata(dmem_wdata_t), .dmem_be(dmem_be_t), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  typedef struct {
    logic rw;
    logic [1:0] sz;
    logic un;
    logic [31:0] a, wd, rd, e_addr, e_wd;
    logic [3:0] e_be;
    logic e_mis;
    logic [31:0] e_rdata;
  } vec_t;
  vec_t v[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nv++;
    if (act !== exp) begin
      nf++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic op(input logic rw, input logic [1:0] sz, input logic un, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; MemRW = rw; MemSize = sz; MemUnsigned = un; addr = a; wdata = wd;
  endtask

  initial begin
    v[0]  = '{1'b0, 2'b00, 1'b0, 32'h103,  32'h0,        32'h80FF1234, 32'h100,  32'h0,        4'hf, 1'b0, 32'hFFFFFF80};
    v[1]  = '{1'b0, 2'b00, 1'b1, 32'h103,  32'h0,        32'h80FF1234, 32'h100,  32'h0,        4'hf, 1'b0, 32'h00000080};
    v[2]  = '{1'b0, 2'b01, 1'b0, 32'h102,  32'h0,        32'h80FF1234, 32'h100,  32'h0,        4'hf, 1'b0, 32'hFFFF80FF};
    v[3]  = '{1'b0, 2'b01, 1'b1, 32'h100,  32'h0,        32'h80FF1234, 32'h100,  32'h0,        4'hf, 1'b0, 32'h00001234};
    v[4]  = '{1'b0, 2'b10, 1'b1, 32'h200,  32'h0,        32'hCAFEBABE, 32'h200,  32'h0,        4'hf, 1'b0, 32'hCAFEBABE};
    v[5]  = '{1'b1, 2'b00, 1'b0, 32'h41,   32'h123456A5, 32'h11111111, 32'h40,   32'hA5A5A5A5, 4'h2, 1'b0, 32'hCAFEBABE};
    v[6]  = '{1'b1, 2'b10, 1'b0, 32'h08,   32'h12345678, 32'h11111111, 32'h08,   32'h12345678, 4'hf, 1'b0, 32'hCAFEBABE};
    v[7]  = '{1'b0, 2'b00, 1'b0, 32'h2,    32'h0,        32'h007F0000, 32'h0,    32'h0,        4'hf, 1'b0, 32'h0000007F};
    v[8]  = '{1'b1, 2'b00, 1'b0, 32'h47,   32'h0000003C, 32'h22222222, 32'h44,   32'h3C3C3C3C, 4'h8, 1'b0, 32'h0000007F};
    v[9]  = '{1'b0, 2'b10, 1'b0, 32'h1002, 32'h0,        32'h0,        32'h0,    32'h0,        4'h0, 1'b1, 32'h0000007F};
    v[10] = '{1'b0, 2'b11, 1'b0, 32'h0,    32'h0,        32'h0,        32'h0,    32'h0,        4'h0, 1'b1, 32'h0000007F};
    v[11] = '{1'b0, 2'b01, 1'b0, 32'h101,  32'h0,        32'h0,        32'h0,    32'h0,        4'h0, 1'b1, 32'h0000007F};
    v[12] = '{1'b1, 2'b01, 1'b0, 32'h3,    32'hFFFF,     32'h0,        32'h0,    32'h0,        4'h0, 1'b1, 32'h0000007F};
    #1;
    chk("rst stall", stall, 0); chk("rst done", done, 0); chk("rst req", dmem_req, 0);
    chk("rst be", dmem_be, 0); chk("rst addr", dmem_addr, 0); chk("rst rdata", rdata, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      op(v[i].rw, v[i].sz, v[i].un, v[i].a, v[i].wd);
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = v[i].rd;
      #1 chk($sformatf("v%0d idle stall", i), stall, 1); chk($sformatf("v%0d idle req", i), dmem_req, 0);
      if (!v[i].e_mis) begin
        @(negedge clk) dmem_gnt = 1'b1;
        #1 chk($sformatf("v%0d req", i), dmem_req, 1);
        chk($sformatf("v%0d addr", i), dmem_addr, v[i].e_addr);
        chk($sformatf("v%0d be", i), dmem_be, v[i].e_be);
        chk($sformatf("v%0d we", i), dmem_we, v[i].rw);
        if (v[i].rw) chk($sformatf("v%0d wdata", i), dmem_wdata, v[i].e_wd);
        @(negedge clk) begin dmem_gnt = 1'b0; dmem_rvalid = 1'b1; end
        #1 chk($sformatf("v%0d wait req", i), dmem_req, 0); chk($sformatf("v%0d wait stall", i), stall, 1);
        chk($sformatf("v%0d wait done", i), done, 0);
      end
      @(negedge clk) dmem_rvalid = 1'b0;
      #1 chk($sformatf("v%0d done", i), done, 1); chk($sformatf("v%0d misalign", i), misalign, v[i].e_mis);
      chk($sformatf("v%0d fault", i), fault, 0); chk($sformatf("v%0d done stall", i), stall, 0);
      chk($sformatf("v%0d rdata", i), rdata, v[i].e_rdata);
      @(negedge clk) req_valid = 1'b0;
      #1 chk($sformatf("v%0d after done", i), done, 0); chk($sformatf("v%0d no reaccept", i), dmem_req, 0);
      chk($sformatf("v%0d after misalign", i), misalign, 0);
    end
    // store half with a grant held off for three cycles
    @(negedge clk) op(1'b1, 2'b01, 1'b0, 32'h22, 32'hDEADBEEF);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk) dmem_gnt = (k == 3);
      #1 chk($sformatf("sh req %0d", k), dmem_req, 1); chk($sformatf("sh addr %0d", k), dmem_addr, 32'h20);
      chk($sformatf("sh wdata %0d", k), dmem_wdata, 32'hBEEFBEEF); chk($sformatf("sh be %0d", k), dmem_be, 4'hC);
      chk($sformatf("sh we %0d", k), dmem_we, 1); chk($sformatf("sh stall %0d", k), stall, 1);
    end
    @(negedge clk) begin dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h99999999; end
    #1 chk("sh wait req", dmem_req, 0);
    @(negedge clk) dmem_rvalid = 1'b0;
    #1 chk("sh done", done, 1); chk("sh rdata kept", rdata, 32'h7F);
    @(negedge clk) req_valid = 1'b0;
    // grant and response in the same REQ cycle
    @(negedge clk) op(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
    @(negedge clk) begin dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h55AA55AA; end
    #1 chk("same req", dmem_req, 1);
    @(negedge clk) begin dmem_gnt = 1'b0; dmem_rvalid = 1'b0; end
    #1 chk("same done", done, 1); chk("same rdata", rdata, 32'h55AA55AA);
    @(negedge clk) req_valid = 1'b0;
    // reset while waiting for a response
    @(negedge clk) begin op(1'b0, 2'b00, 1'b0, 32'h103, 32'h0); dmem_rdata = 32'h80FF1234; end
    @(negedge clk) dmem_gnt = 1'b1;
    @(negedge clk) dmem_gnt = 1'b0;
    #1 chk("rw wait stall", stall, 1);
    rst_n = 1'b0; req_valid = 1'b0;
    #1 chk("rw stall", stall, 0); chk("rw done", done, 0); chk("rw rdata", rdata, 0);
    chk("rw req", dmem_req, 0); chk("rw we", dmem_we, 0); chk("rw addr", dmem_addr, 0);
    chk("rw wdata", dmem_wdata, 0); chk("rw be", dmem_be, 0); chk("rw misalign", misalign, 0);
    chk("rw fault", fault, 0);
    @(negedge clk) begin rst_n = 1'b1; dmem_rvalid = 1'b1; end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1 chk($sformatf("rw no done %0d", k), done, 0); chk($sformatf("rw rdata %0d", k), rdata, 0);
    end
    dmem_rvalid = 1'b0;
    // timeout on the 4-cycle instance, then a late response
    @(negedge clk) op(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    #1 chk("to idle stall", stall_t, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1 chk($sformatf("to req %0d", k), dmem_req_t, 1); chk($sformatf("to nofault %0d", k), fault_t, 0);
    end
    @(negedge clk) begin dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF; end
    #1 chk("to done", done_t, 1); chk("to fault", fault_t, 1); chk("to req low", dmem_req_t, 0);
    chk("to stall", stall_t, 0); chk("to misalign", misalign_t, 0);
    @(negedge clk) req_valid = 1'b0;
    #1 chk("late done", done_t, 0); chk("late fault", fault_t, 0); chk("late rdata", rdata_t, 0);
    @(negedge clk) dmem_rvalid = 1'b0;
    #1 chk("late done2", done_t, 0); chk("late rdata2", rdata_t, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
    $finish;
  end
endmodule
